// File: rtl/pe_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 SRAM port between the W, I and O operand
// streams, with burst locking and read-response routing back to the issuer.
module pe_l2_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [2:0]            req_vld,
  output logic [2:0]            req_rdy,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdat,
  input  logic [3*LEN_W-1:0]    req_len,
  output logic                  mem_vld,
  input  logic                  mem_rdy,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdat,
  input  logic [DATA_W-1:0]     mem_rdat,
  output logic [2:0]            rsp_vld,
  output logic [DATA_W-1:0]     rsp_dat,
  output logic [1:0]            owner,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        owner_q, owner_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        cand0, cand1, cand2;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              sel_vld, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdat;
  logic [LEN_W-1:0]  sel_len, eff_len;
  logic              hs;

  logic              vld_p [RD_LAT];
  logic [1:0]        id_p  [RD_LAT];

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign cand0 = rr_ptr_q;
  assign cand1 = inc3(cand0);
  assign cand2 = inc3(cand1);

  // Grant: registered owner while holding, else first valid from rr_ptr
  always_comb begin
    gnt     = 2'd3;
    gnt_any = 1'b0;
    if (state_q == HOLD) begin
      gnt     = owner_q;
      gnt_any = 1'b1;
    end else if (req_vld[cand0]) begin
      gnt     = cand0;
      gnt_any = 1'b1;
    end else if (req_vld[cand1]) begin
      gnt     = cand1;
      gnt_any = 1'b1;
    end else if (req_vld[cand2]) begin
      gnt     = cand2;
      gnt_any = 1'b1;
    end
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_wdat = '0;
    sel_len  = '0;
    case (gnt)
      2'd0: begin
        sel_vld  = req_vld[0];
        sel_we   = req_we[0];
        sel_addr = req_addr[0*ADDR_W +: ADDR_W];
        sel_wdat = req_wdat[0*DATA_W +: DATA_W];
        sel_len  = req_len[0*LEN_W +: LEN_W];
      end
      2'd1: begin
        sel_vld  = req_vld[1];
        sel_we   = req_we[1];
        sel_addr = req_addr[1*ADDR_W +: ADDR_W];
        sel_wdat = req_wdat[1*DATA_W +: DATA_W];
        sel_len  = req_len[1*LEN_W +: LEN_W];
      end
      2'd2: begin
        sel_vld  = req_vld[2];
        sel_we   = req_we[2];
        sel_addr = req_addr[2*ADDR_W +: ADDR_W];
        sel_wdat = req_wdat[2*DATA_W +: DATA_W];
        sel_len  = req_len[2*LEN_W +: LEN_W];
      end
      default: ;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, even though they are combinational
  always_comb begin
    req_rdy  = 3'b000;
    mem_vld  = arst_n & sel_vld;
    mem_we   = sel_we;
    mem_addr = sel_addr;
    mem_wdat = sel_wdat;
    owner    = (arst_n && gnt_any) ? gnt : 2'd3;
    busy     = (state_q == HOLD);
    hs       = arst_n & sel_vld & mem_rdy;
    if (arst_n && gnt_any) req_rdy[gnt] = mem_rdy;
  end

  assign eff_len = (sel_len == '0) ? LEN_W'(1) : sel_len;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          if (hs) begin
            if (eff_len == LEN_W'(1)) begin
              rr_ptr_d = inc3(gnt);
            end else begin
              state_d = HOLD;
              owner_d = gnt;
              cnt_d   = eff_len - LEN_W'(1);
            end
          end else begin
            // Pending first beat: lock the grant so the beat cannot be stolen
            state_d = HOLD;
            owner_d = gnt;
            cnt_d   = eff_len;
          end
        end
      end
      HOLD: begin
        if (hs) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = inc3(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 2'd0;
      owner_q  <= 2'd3;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  // Response pipeline: stage 0 captures the issuing beat, stage RD_LAT-1 aligns with mem_rdat
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_p[i] <= 1'b0;
        id_p[i]  <= 2'd0;
      end
    end else begin
      vld_p[0] <= hs & ~sel_we;
      id_p[0]  <= gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  assign rsp_vld = vld_p[RD_LAT-1] ? (3'b001 << id_p[RD_LAT-1]) : 3'b000;
  assign rsp_dat = mem_rdat;

endmodule

// File: tb/tb_pe_l2_port_arbiter.sv
// Directed bench for pe_l2_port_arbiter: a transaction-level arbitration and
// response model is checked against the DUT every cycle, plus literal spot checks.
module tb_pe_l2_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;
  localparam int RD_LAT = 2;

  logic                clk;
  logic                arst_n;
  logic [2:0]          req_vld, req_rdy, req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdat;
  logic [3*LEN_W-1:0]  req_len;
  logic                mem_vld, mem_rdy, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdat, mem_rdat;
  logic [2:0]          rsp_vld;
  logic [DATA_W-1:0]   rsp_dat;
  logic [1:0]          owner;
  logic                busy;

  pe_l2_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdat(req_wdat), .req_len(req_len),
    .mem_vld(mem_vld), .mem_rdy(mem_rdy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
    .rsp_vld(rsp_vld), .rsp_dat(rsp_dat), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    int         due;
    logic [7:0] dat;
  } rsp_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  // Model state: who holds the port, beats left in its burst, round-robin start
  int         hold = -1;
  int         rem = 0;
  int         rr = 0;
  rsp_t       q[$];

  // SRAM behavioural model
  logic [7:0] sram [256];
  logic [7:0] dl [RD_LAT];
  logic       rd_fire, wr_fire;
  logic [7:0] rd_a, wr_a, wr_d;

  logic [2:0] last_rdy, last_rsp;
  logic [7:0] last_dat;
  logic [1:0] last_own;
  logic       last_busy, last_mv;
  logic [15:0] last_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [15:0] a, input logic [7:0] d, input logic [7:0] l);
    req_vld[i] = v;
    req_we[i]  = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdat[i*DATA_W +: DATA_W] = d;
    req_len[i*LEN_W +: LEN_W]    = l;
  endtask

  task automatic compare_cycle();
    int         g;
    int         idx;
    int         blen;
    logic       e_mv;
    logic [2:0] e_rdy, e_rv;
    logic [7:0] e_rd;
    logic [1:0] e_own;

    last_rdy = req_rdy; last_rsp = rsp_vld; last_dat = rsp_dat;
    last_own = owner; last_busy = busy; last_mv = mem_vld; last_addr = mem_addr;

    if (!arst_n) begin
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_mem_vld", mem_vld, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 3);
      hold = -1; rem = 0; rr = 0;
      q.delete();
      rd_fire = 1'b0; wr_fire = 1'b0;
      return;
    end

    g = -1;
    if (hold >= 0) g = hold;
    else begin
      for (int k = 0; k < 3; k++) begin
        idx = (rr + k) % 3;
        if (g < 0 && req_vld[idx]) g = idx;
      end
    end

    e_mv  = (g >= 0) && req_vld[g];
    e_rdy = (g >= 0) ? (3'(mem_rdy) << g) : 3'b000;
    e_own = (g >= 0) ? 2'(g) : 2'd3;
    chk("mem_vld", mem_vld, e_mv);
    chk("req_rdy", req_rdy, e_rdy);
    chk("owner", owner, e_own);
    chk("busy", busy, hold >= 0);
    if (e_mv) begin
      chk("mem_we", mem_we, req_we[g]);
      chk("mem_addr", mem_addr, req_addr[g*ADDR_W +: ADDR_W]);
      if (req_we[g]) chk("mem_wdat", mem_wdat, req_wdat[g*DATA_W +: DATA_W]);
    end

    e_rv = 3'b000; e_rd = 8'h00;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_rv = 3'b001 << q[0].id;
      e_rd = q[0].dat;
      q.delete(0);
    end
    chk("rsp_vld", rsp_vld, e_rv);
    if (e_rv != 3'b000) chk("rsp_dat", rsp_dat, e_rd);

    // Advance the model by one clock
    if (e_mv && mem_rdy) begin
      if (!req_we[g]) begin
        rsp_t r;
        r.id  = g;
        r.due = cyc + RD_LAT;
        r.dat = sram[req_addr[g*ADDR_W +: 8]];
        q.push_back(r);
      end
      if (hold < 0) begin
        blen = (req_len[g*LEN_W +: LEN_W] == 0) ? 1 : int'(req_len[g*LEN_W +: LEN_W]);
        if (blen > 1) begin hold = g; rem = blen - 1; end
        else rr = (g + 1) % 3;
      end else begin
        rem--;
        if (rem == 0) begin rr = (hold + 1) % 3; hold = -1; end
      end
    end else if (hold < 0 && g >= 0) begin
      blen = (req_len[g*LEN_W +: LEN_W] == 0) ? 1 : int'(req_len[g*LEN_W +: LEN_W]);
      hold = g; rem = blen;
    end

    rd_fire = mem_vld && mem_rdy && !mem_we;
    wr_fire = mem_vld && mem_rdy && mem_we;
    rd_a = mem_addr[7:0]; wr_a = mem_addr[7:0]; wr_d = mem_wdat;
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = RD_LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = rd_fire ? sram[rd_a] : 8'h00;
    if (wr_fire) sram[wr_a] = wr_d;
    mem_rdat = dl[RD_LAT-1];
  endtask

  initial begin
    arst_n = 1'b0; mem_rdy = 1'b0; mem_rdat = 8'h00;
    req_vld = '0; req_we = '0; req_addr = '0; req_wdat = '0; req_len = '0;
    rd_fire = 1'b0; wr_fire = 1'b0; rd_a = 0; wr_a = 0; wr_d = 0;
    for (int a = 0; a < 256; a++) sram[a] = 8'(a) ^ 8'hA5;
    for (int i = 0; i < RD_LAT; i++) dl[i] = 8'h00;
    #1;
    step(); step();
    arst_n = 1'b1;
    step();

    // Reset in the middle of a held burst
    mem_rdy = 1'b1;
    set_req(0, 1, 0, 16'h0010, 8'h00, 8'd4);
    step();
    mem_rdy = 1'b0;
    step();
    chk("t1_busy_hold", last_busy, 1);
    mem_rdy = 1'b1;
    arst_n = 1'b0;
    step();
    chk("t1_owner_rst", last_own, 3);
    chk("t1_rdy_rst", last_rdy, 0);
    chk("t1_mv_rst", last_mv, 0);
    arst_n = 1'b1;
    set_req(0, 0, 0, 16'h0010, 8'h00, 8'd1);
    step();

    // Three single-beat reads, round-robin from W
    set_req(0, 1, 0, 16'h0010, 8'h00, 8'd1);
    set_req(1, 1, 0, 16'h0020, 8'h00, 8'd1);
    set_req(2, 1, 0, 16'h0030, 8'h00, 8'd1);
    step();
    chk("t2_own_w", last_own, 0);
    set_req(0, 0, 0, 16'h0010, 8'h00, 8'd1);
    step();
    chk("t2_own_i", last_own, 1);
    set_req(1, 0, 0, 16'h0020, 8'h00, 8'd1);
    step();
    chk("t2_own_o", last_own, 2);
    chk("t2_rsp_w", last_rsp, 3'b001);
    chk("t2_dat_w", last_dat, 8'hB5);
    set_req(2, 0, 0, 16'h0030, 8'h00, 8'd1);
    step();
    chk("t2_rsp_i", last_rsp, 3'b010);
    chk("t2_dat_i", last_dat, 8'h85);
    step();
    chk("t2_rsp_o", last_rsp, 3'b100);
    chk("t2_dat_o", last_dat, 8'h95);

    // I write burst of 4 locks out W
    set_req(0, 1, 0, 16'h0040, 8'h00, 8'd1);
    step();
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1, 1, 16'h0050 + 16'(b), 8'hC0 + 8'(b), 8'd4);
      set_req(0, 1, 0, 16'h0041, 8'h00, 8'd1);
      step();
      chk("t3_rdy_burst", last_rdy, 3'b010);
      chk("t3_own_burst", last_own, 1);
    end
    set_req(1, 0, 0, 16'h0000, 8'h00, 8'd1);
    step();
    chk("t3_own_w", last_own, 0);
    chk("t3_rdy_w", last_rdy, 3'b001);
    set_req(0, 0, 0, 16'h0000, 8'h00, 8'd1);
    step();
    step();
    chk("t3_rsp_w", last_rsp, 3'b001);
    chk("t3_dat_w", last_dat, 8'hE4);

    // Stalled SRAM keeps O's pending beat owned
    mem_rdy = 1'b0;
    set_req(2, 1, 0, 16'h0300, 8'h00, 8'd1);
    set_req(0, 1, 0, 16'h0044, 8'h00, 8'd1);
    step();
    chk("t4_own_s0", last_own, 2);
    chk("t4_busy_s0", last_busy, 0);
    for (int s = 0; s < 2; s++) begin
      step();
      chk("t4_addr_stall", last_addr, 16'h0300);
      chk("t4_own_stall", last_own, 2);
      chk("t4_busy_stall", last_busy, 1);
      chk("t4_rdy_stall", last_rdy, 3'b000);
    end
    mem_rdy = 1'b1;
    step();
    chk("t4_rdy_go", last_rdy, 3'b100);
    set_req(2, 0, 0, 16'h0000, 8'h00, 8'd1);
    step();
    chk("t4_own_w", last_own, 0);
    set_req(0, 0, 0, 16'h0000, 8'h00, 8'd1);
    step();
    chk("t4_rsp_o", last_rsp, 3'b100);
    chk("t4_dat_o", last_dat, 8'hA5);
    step();
    chk("t4_rsp_w", last_rsp, 3'b001);
    chk("t4_dat_w", last_dat, 8'hE1);

    // len=0 and len=1 are single beats
    set_req(1, 1, 0, 16'h0060, 8'h00, 8'd0);
    step();
    chk("t5_own_len0", last_own, 1);
    chk("t5_busy_len0", last_busy, 0);
    set_req(1, 0, 0, 16'h0000, 8'h00, 8'd0);
    set_req(2, 1, 0, 16'h0061, 8'h00, 8'd1);
    step();
    chk("t5_own_len1", last_own, 2);
    chk("t5_busy_len1", last_busy, 0);
    set_req(2, 0, 0, 16'h0000, 8'h00, 8'd1);
    step();
    chk("t5_own_none", last_own, 3);
    chk("t5_busy_none", last_busy, 0);
    chk("t5_rsp_i", last_rsp, 3'b010);
    chk("t5_dat_i", last_dat, 8'hC5);
    step();
    chk("t5_rsp_o", last_rsp, 3'b100);
    chk("t5_dat_o", last_dat, 8'hC4);

    // Back-to-back reads of the burst-written data
    set_req(0, 1, 0, 16'h0052, 8'h00, 8'd1);
    step();
    set_req(0, 0, 0, 16'h0000, 8'h00, 8'd1);
    set_req(1, 1, 0, 16'h0053, 8'h00, 8'd1);
    step();
    set_req(1, 0, 0, 16'h0000, 8'h00, 8'd1);
    step();
    chk("t6_rsp_w", last_rsp, 3'b001);
    chk("t6_dat_w", last_dat, 8'hC2);
    step();
    chk("t6_rsp_i", last_rsp, 3'b010);
    chk("t6_dat_i", last_dat, 8'hC3);
    step(); step(); step();
    chk("q_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_l2_port_arbiter.md
Name: pe_l2_port_arbiter

Overview:
- Round-robin arbiter that shares one L2 SRAM port between the PE's three operand streams: W (index 0), I (index 1) and O (index 2).
- Each requester uses a vld/rdy handshake and may lock the port for a multi-beat burst.
- Read responses return from the SRAM after a fixed latency. The block routes each one back to the requester that issued the read.
- Sits between the Catapult-generated PE I/O port wrappers and the L2 memory macro.

Parameters:
- ADDR_W, 16, L2 address width
- DATA_W, 8, data width
- LEN_W, 8, burst length field width
- RD_LAT, 2, SRAM read latency in cycles (>=1)

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- req_vld  in  3  per-requester beat valid
- req_rdy  out  3  per-requester beat accepted
- req_we  in  3  per-requester write enable (1 = write)
- req_addr  in  3*ADDR_W  per-requester address; slice i at [i*ADDR_W +: ADDR_W]
- req_wdat  in  3*DATA_W  per-requester write data
- req_len  in  3*LEN_W  burst length in beats; sampled on the first beat only
- mem_vld  out  1  SRAM request valid
- mem_rdy  in  1  SRAM accepts request
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdat  out  DATA_W  SRAM write data
- mem_rdat  in  DATA_W  SRAM read data, valid RD_LAT cycles after an accepted read
- rsp_vld  out  3  per-requester read-data valid
- rsp_dat  out  DATA_W  read data, shared by all requesters
- owner  out  2  current grant index; 3 = none
- busy  out  1  high while in HOLD

Behaviour:
- Reset (arst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, cnt=0, owner=3.
  - Response pipeline cleared.
  - All of req_rdy, mem_vld, rsp_vld and busy are 0.
  - A burst in progress at reset is dropped, with no completion.
- Grant g:
  - IDLE: g = first i with req_vld[i] set, searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). This is combinational, so a beat can pass in the same cycle.
  - HOLD: g = registered owner.
- Datapath (combinational):
  - mem_vld = req_vld[g]; mem_we/addr/wdat come from slice g.
  - req_rdy[g] = mem_rdy; all other req_rdy bits are 0.
  - If no requester is valid: mem_vld=0 and owner=3.
- FSM IDLE, on grant g:
  - Handshake with effective len<=1 (len 0 is treated as 1): stay IDLE, rr_ptr<=g+1 mod 3.
  - Handshake with len>1: go to HOLD, owner<=g, cnt<=len-1.
  - req_vld[g] high but mem_rdy low: go to HOLD, owner<=g, cnt<=len (len 0 treated as 1). This keeps the grant stable while a beat is pending.
- FSM HOLD:
  - Only the owner is connected.
  - Each handshake decrements cnt. The handshake with cnt==1 returns to IDLE and sets rr_ptr<=owner+1.
  - The owner dropping req_vld mid-burst is legal and the grant stays held.
  - Other requesters wait with req_rdy=0.
- Read return:
  - An RD_LAT-stage shift register carries {valid, id}. Each accepted beat pushes {~mem_we, g}.
  - At the tail, rsp_vld[id] = valid and rsp_dat = mem_rdat. The requester has no backpressure on responses.
  - Writes push valid=0.
- Simultaneous events: reads from different bursts may overlap in the pipeline. Responses return in issue order, one per cycle.
- Starvation bound: a requester waits at most two other bursts.

Test Plan:
1. Reset mid-HOLD with cnt=3 -> all outputs 0 immediately, owner=3; after release, IDLE with rr_ptr=0.
2. All three requesters post single-beat reads with mem_rdy=1 for 3 cycles -> grants W, I, O in that order. With RD_LAT=2, rsp_vld = 001, 010, 100 on cycles 3, 4, 5, with rsp_dat equal to each address's data.
3. I posts a write burst with len=4 while W is also valid -> I holds 4 beats, W's req_rdy stays 0, and W is granted on cycle 5. rr_ptr then moves to W+1.
4. mem_rdy low for 3 cycles with O's first beat pending and W asserting -> mem_addr stays at O's address, owner=2, busy=1. The beat transfers when mem_rdy rises.
5. len=0 and len=1 single reads -> each transfers exactly one beat, FSM stays IDLE, busy=0.
6. Back-to-back reads from W then I with mem_rdy=1 -> rsp_vld toggles 001 then 010 on consecutive cycles, with no bubble and no misrouting.
